// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared widths, funct3 op codes, FSM states and special-case constants for md_sequencer
package md_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MD_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] MD_INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// rtl/md_iter_step.sv - one combinational shift-add multiply or restoring-divide iteration on a {hi, lo} pair
module md_iter_step
    import md_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + {1'b0, operand};
        shifted = {hi_in, lo_in[XLEN-1]};
        // rem < divisor keeps a non-borrowing difference below 2^32, so bit XLEN is the borrow
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            if (diff[XLEN]) begin
                hi_out = shifted[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b0};
            end else begin
                hi_out = diff[XLEN-1:0];
                lo_out = {lo_in[XLEN-2:0], 1'b1};
            end
        end else if (lo_in[0]) begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end else begin
            hi_out = {1'b0, hi_in[XLEN-1:1]};
            lo_out = {hi_in[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - RV32M multi-cycle multiply/divide sequencer for EX; MD_FAST_MUL_EN selects single-cycle multiply
module md_sequencer
    import md_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MDStart_ex,
    input  logic [2:0]      MDOp_ex,
    input  logic [XLEN-1:0] MDA_ex,
    input  logic [XLEN-1:0] MDB_ex,
    input  logic            Flush_ex,
    output logic            Stall_md,
    output logic            MDDone_ex,
    output logic [XLEN-1:0] MDResult_ex
);

    md_state_e       state;
    logic [4:0]      cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opd_q;
    logic            neg_q;

    logic            a_sgn;
    logic            b_sgn;
    logic            start_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_res;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fin_res;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;

    assign Stall_md = MDStart_ex & ~MDDone_ex;

    // Operands are reduced to magnitudes at capture; the sign is restored once at the end
    always_comb begin
        a_sgn = MDA_ex[XLEN-1] & (MDOp_ex == OP_MULH || MDOp_ex == OP_MULHSU ||
                                  MDOp_ex == OP_DIV  || MDOp_ex == OP_REM);
        b_sgn = MDB_ex[XLEN-1] & (MDOp_ex == OP_MULH || MDOp_ex == OP_DIV ||
                                  MDOp_ex == OP_REM);
        a_mag = a_sgn ? -MDA_ex : MDA_ex;
        b_mag = b_sgn ? -MDB_ex : MDB_ex;
        start_neg = (MDOp_ex == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero  = op_is_div(MDOp_ex) && (MDB_ex == '0);
        div_ovf   = (MDOp_ex == OP_DIV || MDOp_ex == OP_REM) &&
                    (MDA_ex == MD_INT_MIN) && (MDB_ex == MD_ALL_ONES);
        if (div_zero) begin
            special_res = MDOp_ex[1] ? MDA_ex : MD_ALL_ONES;
        end else begin
            special_res = MDOp_ex[1] ? '0 : MD_INT_MIN;
        end
    end

`ifdef MD_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // Sign-extended 64-bit operands give the correct low 64 product bits for every signedness mix
    assign fast_prod = {{XLEN{a_sgn}}, MDA_ex} * {{XLEN{b_sgn}}, MDB_ex};
    assign fast_hit  = !op_is_div(MDOp_ex);
    assign fast_res  = (MDOp_ex == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_hit  = 1'b0;
    assign fast_res  = '0;
`endif

    md_iter_step u_step (
        .is_div  (op_is_div(op_q)),
        .hi_in   (hi_q),
        .lo_in   (lo_q),
        .operand (opd_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        div_sel  = op_q[1] ? step_hi : step_lo;
        if (op_is_div(op_q)) begin
            fin_res = neg_q ? -div_sel : div_sel;
        end else if (op_q == OP_MUL) begin
            fin_res = prod_fix[XLEN-1:0];
        end else begin
            fin_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opd_q       <= '0;
            neg_q       <= 1'b0;
            MDDone_ex   <= 1'b0;
            MDResult_ex <= '0;
        end else begin
            MDDone_ex <= 1'b0;
            case (state)
                IDLE: begin
                    if (MDStart_ex && !Flush_ex) begin
                        op_q  <= MDOp_ex;
                        hi_q  <= '0;
                        lo_q  <= a_mag;
                        opd_q <= b_mag;
                        neg_q <= start_neg;
                        cnt   <= 5'd31;
                        if (div_zero || div_ovf) begin
                            MDResult_ex <= special_res;
                            MDDone_ex   <= 1'b1;
                            state       <= DONE;
                        end else if (fast_hit) begin
                            MDResult_ex <= fast_res;
                            MDDone_ex   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (Flush_ex) begin
                        state <= IDLE;
                    end else begin
                        hi_q <= step_hi;
                        lo_q <= step_lo;
                        cnt  <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            MDResult_ex <= fin_res;
                            MDDone_ex   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - scoreboard bench for md_sequencer (honours MD_FAST_MUL_EN for multiply latency)
module tb_md_sequencer;
    import md_pkg::*;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int ITR_LAT = 33;
    localparam int SPC_LAT = 1;

    localparam int K_DONE = 0;
    localparam int K_RES  = 1;
    localparam int K_IDLE = 2;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } probe_t;

    logic        clk;
    logic        rst_n;
    logic        MDStart_ex;
    logic [2:0]  MDOp_ex;
    logic [31:0] MDA_ex;
    logic [31:0] MDB_ex;
    logic        Flush_ex;
    logic        Stall_md;
    logic        MDDone_ex;
    logic [31:0] MDResult_ex;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    int     cyc = 0;
    int     pass_cnt = 0;
    int     total_cnt = 0;
    int     n_done = 0;
    int     t0 = 0;
    bit     tracking = 1'b0;
    bit     stall_ok = 1'b1;
    bit     fin_req = 1'b0;
    bit     fin_ack = 1'b0;

    md_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MDStart_ex  (MDStart_ex),
        .MDOp_ex     (MDOp_ex),
        .MDA_ex      (MDA_ex),
        .MDB_ex      (MDB_ex),
        .Flush_ex    (Flush_ex),
        .Stall_md    (Stall_md),
        .MDDone_ex   (MDDone_ex),
        .MDResult_ex (MDResult_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, pending=%0d", exp_q.size());
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Monitor: pops expectations on each done pulse and services stimulus probes
    always @(negedge clk) begin
        exp_t   e;
        probe_t p;
        if (!rst_n) begin
            tracking = 1'b0;
        end else begin
            if (MDDone_ex) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk($sformatf("done_with_pending#%0d", n_done), 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("result#%0d", n_done), MDResult_ex, e.res);
                    chk($sformatf("latency#%0d", n_done), 32'(cyc - t0), 32'(e.lat));
                    chk($sformatf("stall#%0d", n_done), {30'b0, stall_ok, Stall_md}, 32'd2);
                end
                tracking = 1'b0;
            end else if (!tracking && MDStart_ex && !Flush_ex) begin
                tracking = 1'b1;
                t0       = cyc;
                stall_ok = 1'b1;
            end
            if (tracking && !MDDone_ex && !Stall_md) stall_ok = 1'b0;
            if (tracking && Flush_ex) tracking = 1'b0;
        end
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.kind)
                K_DONE:  chk("probe_done", {31'b0, MDDone_ex}, p.val);
                K_RES:   chk("probe_result", MDResult_ex, p.val);
                default: chk("probe_state_idle", 32'(u_dut.state), p.val);
            endcase
        end
        if (fin_req && !fin_ack) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            fin_ack = 1'b1;
        end
    end

    task automatic probe(input int k, input logic [31:0] v);
        probe_q.push_back('{k, v});
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        @(posedge clk); #1;
        exp_q.push_back('{res, lat});
        MDOp_ex    = op;
        MDA_ex     = a;
        MDB_ex     = b;
        MDStart_ex = 1'b1;
        @(posedge clk); #1;
        MDA_ex = $urandom;
        MDB_ex = $urandom;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (MDDone_ex) break;
        end
        if (!MDDone_ex) probe(K_DONE, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        MDStart_ex = 1'b0;
        MDOp_ex    = 3'd0;
        MDA_ex     = '0;
        MDB_ex     = '0;
        Flush_ex   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        probe(K_DONE, 32'd0);
        probe(K_RES, 32'd0);
        probe(K_IDLE, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        issue(OP_DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, ITR_LAT);
        issue(OP_REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, ITR_LAT);
        issue(OP_DIVU,   32'd100,        32'd7,         32'd14,        ITR_LAT);
        issue(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, SPC_LAT);
        issue(OP_REMU,   32'd5,          32'd0,         32'd5,         SPC_LAT);
        issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPC_LAT);
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        issue(OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, ITR_LAT);
        issue(OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         ITR_LAT);
        issue(OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPC_LAT);
        issue(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         ITR_LAT);
        issue(OP_MUL,    32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,        MUL_LAT);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, MUL_LAT);
        issue(OP_REMU,   32'd100,        32'd7,         32'd2,         ITR_LAT);

        // Flush a divide in flight: no done, result keeps the REMU value
        @(posedge clk); #1;
        MDOp_ex = OP_DIV; MDA_ex = 32'hFFFF_FFEC; MDB_ex = 32'd3; MDStart_ex = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        Flush_ex = 1'b1;
        probe(K_DONE, 32'd0);
        @(posedge clk); #1;
        Flush_ex   = 1'b0;
        MDStart_ex = 1'b0;
        probe(K_IDLE, 32'd0);
        probe(K_DONE, 32'd0);
        probe(K_RES, 32'd2);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, ITR_LAT);

        // Reset in the middle of a divide clears outputs at once
        @(posedge clk); #1;
        MDOp_ex = OP_DIV; MDA_ex = 32'hFFFF_FFEC; MDB_ex = 32'd3; MDStart_ex = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        rst_n      = 1'b0;
        MDStart_ex = 1'b0;
        probe(K_DONE, 32'd0);
        probe(K_RES, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        issue(OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        @(posedge clk); #1;
        MDStart_ex = 1'b0;
        repeat (3) @(posedge clk);
        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle RV32M multiply/divide sequencer attached to the EX stage, next to the ALU and forwarding muxes. It accepts the forwarded operands of an M-extension instruction held in EX, runs an iterative shift-add or restoring-divide sequence, and stalls the pipeline until the result is ready. On completion it presents a 32-bit result that the EX result mux selects in place of the ALU result.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  input  1  pipeline clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- MDStart_ex  input  1  level; an M-extension instruction occupies EX.
- MDOp_ex  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- MDA_ex  input  32  forwarded rs1 operand.
- MDB_ex  input  32  forwarded rs2 operand.
- Flush_ex  input  1  squashes the EX instruction (branch/exception).
- Stall_md  output  1  hold IF/ID/EX; combinational: MDStart_ex & ~MDDone_ex.
- MDDone_ex  output  1  one-cycle result-valid pulse.
- MDResult_ex  output  32  result; held until the next accepted start.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if MDStart_ex & ~Flush_ex, capture op and operands, then go to BUSY. Special cases go straight to DONE with a fixed result:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- BUSY: one iteration per cycle; 5-bit counter counts from 31 down to 0. When the counter reaches 0, apply sign fixup, register the result, and go to DONE.
- DONE: MDDone_ex=1 for exactly one cycle, then return to IDLE unconditionally. The instruction leaves EX on this edge.
- Signed ops work on magnitudes with a final conditional negate:
  - Product is negative iff the operand signs differ. MULHSU treats only A as signed.
  - Quotient is negative iff the operand signs differ. Remainder takes the sign of the dividend.
- The 64-bit product is formed internally. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Operand changes after capture are ignored.
- MDStart_ex seen in BUSY or DONE does not start a new operation.
- Flush_ex in BUSY or DONE returns to IDLE on the next edge with no MDDone_ex pulse. MDResult_ex keeps its previous value. Flush has priority over completion.
- Reset: state IDLE, counter 0, MDDone_ex 0, MDResult_ex 0, all internal registers 0. Asserting rst_n mid-operation aborts the operation with no done pulse.

## Timing
- Start accepted at edge T (i.e. sampled in IDLE during cycle T).
- Iterative ops: BUSY for T+1..T+32; MDDone_ex and result valid during cycle T+33. Stall_md is high during cycles T..T+32 and low at T+33.
- Special-case divides and fast multiplies: MDDone_ex during cycle T+1. Stall_md is high during cycle T only.
- Back-to-back M instructions: the next start is accepted in the IDLE cycle following DONE.

## Configuration
- MD_FAST_MUL_EN defined: all multiply ops complete in a single combinational 32x32 multiply stage; latency is that of the special cases, with done at T+1.
- MD_FAST_MUL_EN undefined: multiplies use the 32-iteration shift-add path, done at T+33. Divide behaviour is identical in both builds.

## Structure
- Package md_pkg holds:
  - XLEN;
  - the op funct3 localparams;
  - the state enum (IDLE/BUSY/DONE);
  - the special-case constants 0xFFFFFFFF and 0x80000000.
- Sub-module md_iter_step: purely combinational single-iteration step.
  - Multiply: conditional add plus shift of the {acc, multiplier} pair.
  - Divide: shift, trial subtract, restore of the {rem, quotient} pair.
  - Instantiated once; the FSM and counter live in md_sequencer.

## Test plan
- MUL 7 x 0xFFFFFFFD: MDResult_ex=0xFFFFFFEB. Done at T+33, or T+1 with MD_FAST_MUL_EN. Stall_md high every cycle before done.
- DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA; REM of the same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14. Each has done at T+33.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All complete with done at T+1.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Flush_ex at T+10 of a DIV: state is IDLE at T+11 with no done pulse and MDResult_ex unchanged. A following DIVU 100/7 yields 14.
- rst_n low at T+5 of a DIV: MDDone_ex=0 and MDResult_ex=0 immediately. After release, MUL 3 x 4 -> 12.
